// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order writeback FIFO feeding the register file write port with decode forwarding
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_mem_valid,
  input  logic [4:0]                   i_mem_index,
  input  logic [31:0]                  i_mem_data,
  input  logic                         i_alu_valid,
  input  logic [4:0]                   i_alu_index,
  input  logic [31:0]                  i_alu_data,
  output logic                         o_in_ready,
  output logic [4:0]                   o_write_index,
  output logic [31:0]                  o_write_data,
  output logic                         o_write_enable,
  input  logic [4:0]                   i_read_index1,
  input  logic [4:0]                   i_read_index2,
  output logic                         o_pending1,
  output logic                         o_pending2,
  output logic [31:0]                  o_fwd_data1,
  output logic [31:0]                  o_fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [4:0]    r_idx [DEPTH];
  logic [31:0]   r_dat [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [4:0]    r_wi;
  logic [31:0]   r_wd;
  logic          w_push_mem, w_push_alu, w_pop;
  logic [AW-1:0] w_alu_slot;
  // Room for two means at most DEPTH-2 occupied; a single source still needs the full two slots free
  assign o_in_ready = r_count <= CW'(DEPTH - 2);
  assign w_push_mem = o_in_ready && i_mem_valid && (i_mem_index != '0);
  assign w_push_alu = o_in_ready && i_alu_valid && (i_alu_index != '0);
  assign w_alu_slot = r_tail + AW'(w_push_mem);
  assign w_pop      = r_count != '0;
  assign o_count        = r_count;
  assign o_write_enable = r_we;
  assign o_write_index  = r_wi;
  assign o_write_data   = r_wd;
  // Entry storage: mem lands at the tail, alu right behind it so the older instruction drains first
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_idx[k] <= '0;
        r_dat[k] <= '0;
      end
    end else begin
      if (w_push_mem) begin
        r_idx[r_tail] <= i_mem_index;
        r_dat[r_tail] <= i_mem_data;
      end
      if (w_push_alu) begin
        r_idx[w_alu_slot] <= i_alu_index;
        r_dat[w_alu_slot] <= i_alu_data;
      end
    end
  end
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + AW'(w_push_mem) + AW'(w_push_alu);
      r_head  <= r_head + AW'(w_pop);
      r_count <= r_count + CW'(w_push_mem) + CW'(w_push_alu) - CW'(w_pop);
    end
  end
  // Head entry moves into the write-port registers every cycle the queue is non-empty
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_we <= 1'b0;
      r_wi <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_wi <= r_idx[r_head];
        r_wd <= r_dat[r_head];
      end
    end
  end
  // Newest match wins: output register first, then queue entries head to tail overwrite it
  function automatic logic [32:0] lookup(input logic [4:0] ri);
    logic [32:0]   res;
    logic [AW-1:0] p;
    res = (r_we && r_wi == ri) ? {1'b1, r_wd} : 33'd0;
    for (int k = 0; k < DEPTH; k++) begin
      p = r_head + AW'(k);
      if (CW'(k) < r_count && r_idx[p] == ri) res = {1'b1, r_dat[p]};
    end
    return (ri == '0) ? 33'd0 : res;
  endfunction
  assign {o_pending1, o_fwd_data1} = lookup(i_read_index1);
  assign {o_pending2, o_fwd_data2} = lookup(i_read_index2);
endmodule
